// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_stage_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   localparam logic [1:0] PCSRC_PLUS4  = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;
   localparam logic [1:0] PCSRC_TRAP   = 2'b10;
   localparam logic [1:0] PCSRC_RSVD   = 2'b11;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_FETCH = 2'd1,
      ST_HOLD  = 2'd2,
      ST_DROP  = 2'd3
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus; fetch side is master, memory is slave.
interface fetch_stage_if #(parameter int XLEN = 32);
   logic            imemReq;
   logic [XLEN-1:0] imemAddr;
   logic            imemReady;
   logic [XLEN-1:0] imemRdata;

   modport master (output imemReq, imemAddr, input imemReady, imemRdata);
   modport slave  (input imemReq, imemAddr, output imemReady, imemRdata);
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clr or an empty load inserts a NOP bubble, en=0 freezes contents.
// One cycle latency; no backpressure of its own (the enable is the stall).
module if_id_reg
   import fetch_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            clr,
   input  logic            load_vld,
   input  logic [31:0]     load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            vld
);

   logic [31:0]     instr_q, instr_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
   logic            vld_q, vld_d;

   always_comb begin
      instr_d    = instr_q;
      pc_d       = pc_q;
      pc_plus4_d = pc_plus4_q;
      vld_d      = vld_q;
      if (clr || (en && !load_vld)) begin
         instr_d    = NOP_INSTR;
         pc_d       = '0;
         pc_plus4_d = '0;
         vld_d      = 1'b0;
      end else if (en) begin
         instr_d    = load_instr;
         pc_d       = load_pc;
         pc_plus4_d = load_pc + XLEN'(4);
         vld_d      = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q    <= NOP_INSTR;
         pc_q       <= '0;
         pc_plus4_q <= '0;
         vld_q      <= 1'b0;
      end else begin
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         pc_plus4_q <= pc_plus4_d;
         vld_q      <= vld_d;
      end
   end

   assign instr    = instr_q;
   assign pc       = pc_q;
   assign pc_plus4 = pc_plus4_q;
   assign vld      = vld_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues imem requests, feeds decode via IF/ID one cycle after each response.
// Stall parks an accepted word in a one-entry skid buffer with req dropped; a redirect during an outstanding request drains the stale response.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                flush,
   input  logic                redirect,
   input  logic [1:0]          pcSrc,
   input  logic [XLEN-1:0]     pcTarget,
   input  logic [XLEN-1:0]     trapVec,
   fetch_stage_if.master       imem,
   output logic [31:0]         instrD,
   output logic [6:0]          opD,
   output logic [XLEN-1:0]     pcD,
   output logic [XLEN-1:0]     pcPlus4D,
   output logic                validD
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] stale_addr_q, stale_addr_d;
   logic [XLEN-1:0] skid_pc_q, skid_pc_d;
   logic [31:0]     skid_instr_q, skid_instr_d;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] new_pc;
   logic [XLEN-1:0] sel_pc;
   logic            id_vld;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;

   assign pc_plus4 = pc_q + XLEN'(4);

   always_comb begin
      sel_pc = pc_plus4;
      case (pcSrc)
         PCSRC_TARGET:             sel_pc = pcTarget;
         PCSRC_TRAP:               sel_pc = trapVec;
         PCSRC_PLUS4, PCSRC_RSVD:  sel_pc = pc_plus4;
         default:                  sel_pc = pc_plus4;
      endcase
      new_pc = word_align(sel_pc);
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      stale_addr_d = stale_addr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      imem_req     = 1'b0;
      imem_addr    = pc_q;
      id_vld       = 1'b0;
      id_instr     = NOP_INSTR;
      id_pc        = pc_q;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_FETCH;
            if (redirect) pc_d = new_pc;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (redirect) begin
               pc_d = new_pc;
               // Memory still owes a response for pc_q; keep presenting it until it arrives.
               if (!imem.imemReady) begin
                  state_d      = ST_DROP;
                  stale_addr_d = pc_q;
               end
            end else if (flush) begin
               state_d = ST_FETCH;
            end else if (imem.imemReady) begin
               pc_d = pc_plus4;
               if (stall) begin
                  skid_instr_d = imem.imemRdata;
                  skid_pc_d    = pc_q;
                  state_d      = ST_HOLD;
               end else begin
                  id_vld   = 1'b1;
                  id_instr = imem.imemRdata;
                  id_pc    = pc_q;
               end
            end
         end
         ST_HOLD: begin
            if (redirect) begin
               pc_d    = new_pc;
               state_d = ST_FETCH;
            end else if (flush) begin
               state_d = ST_FETCH;
            end else if (!stall) begin
               id_vld   = 1'b1;
               id_instr = skid_instr_q;
               id_pc    = skid_pc_q;
               state_d  = ST_FETCH;
            end
         end
         ST_DROP: begin
            imem_req  = 1'b1;
            imem_addr = stale_addr_q;
            if (redirect)        pc_d    = new_pc;
            if (imem.imemReady)  state_d = ST_FETCH;
         end
         default: state_d = ST_BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         stale_addr_q <= '0;
         skid_pc_q    <= '0;
         skid_instr_q <= NOP_INSTR;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         stale_addr_q <= stale_addr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
      end
   end

   assign imem.imemReq  = imem_req;
   assign imem.imemAddr = imem_addr;

   if_id_reg #(.XLEN(XLEN)) u_if_id (
      .clk        (clk),
      .rst        (rst),
      .en         (!stall),
      .clr        (flush | redirect),
      .load_vld   (id_vld),
      .load_instr (id_instr),
      .load_pc    (id_pc),
      .instr      (instrD),
      .pc         (pcD),
      .pc_plus4   (pcPlus4D),
      .vld        (validD)
   );

   assign opD = instrD[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns {addr[27:0],4'h3} for every fetch.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, flush, redirect;
   logic [1:0]  pcSrc;
   logic [31:0] pcTarget, trapVec;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_stage_if #(.XLEN(32)) imem_a ();
   fetch_stage_if #(.XLEN(32)) imem_b ();

   logic [31:0] instr_a, pc_a, pc4_a, instr_b, pc_b, pc4_b;
   logic [6:0]  op_a, op_b;
   logic        vld_a, vld_b;

   always_comb imem_a.imemRdata = {imem_a.imemAddr[27:0], 4'h3};
   always_comb imem_b.imemRdata = {imem_b.imemAddr[27:0], 4'h3};
   assign imem_b.imemReady = 1'b1;

   fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
      .pcSrc(pcSrc), .pcTarget(pcTarget), .trapVec(trapVec), .imem(imem_a),
      .instrD(instr_a), .opD(op_a), .pcD(pc_a), .pcPlus4D(pc4_a), .validD(vld_a)
   );

   fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC)) u_dut_hi (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
      .pcSrc(pcSrc), .pcTarget(pcTarget), .trapVec(trapVec), .imem(imem_b),
      .instrD(instr_b), .opD(op_b), .pcD(pc_b), .pcPlus4D(pc4_b), .validD(vld_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
      pcSrc = 2'b00; pcTarget = '0; trapVec = '0;
      imem_a.imemReady = 1'b1;
      step(); step();
      @(negedge clk);
      chk("rst_req",   32'(imem_a.imemReq), 32'd0);
      chk("rst_vld",   32'(vld_a),          32'd0);
      chk("rst_instr", instr_a,             32'h0000_0013);
      chk("rst_pcD",   pc_a,                32'h0);
      chk("rst_pc4D",  pc4_a,               32'h0);

      // c1: BOOT
      step(); rst = 1'b0;
      @(negedge clk);
      chk("boot_req", 32'(imem_a.imemReq), 32'd0);
      chk("boot_vld", 32'(vld_a),          32'd0);
      // c2: first fetch
      step(); @(negedge clk);
      chk("f0_req",  32'(imem_a.imemReq), 32'd1);
      chk("f0_addr", imem_a.imemAddr,     32'h0);
      chk("f0_vld",  32'(vld_a),          32'd0);
      chk("hi_addr0", imem_b.imemAddr,    32'hFFFF_FFFC);
      // c3
      step(); @(negedge clk);
      chk("f1_addr",  imem_a.imemAddr, 32'h4);
      chk("f1_vld",   32'(vld_a),      32'd1);
      chk("f1_pcD",   pc_a,            32'h0);
      chk("f1_instr", instr_a,         32'h0000_0003);
      chk("hi_addr1", imem_b.imemAddr, 32'h0);
      chk("hi_pcD",   pc_b,            32'hFFFF_FFFC);
      chk("hi_pc4D",  pc4_b,           32'h0);
      chk("hi_instr", instr_b,         32'hFFFF_FFC3);
      // c4: addr 8 with ready low for 3 cycles
      step(); imem_a.imemReady = 1'b0;
      @(negedge clk);
      chk("f2_addr",  imem_a.imemAddr, 32'h8);
      chk("f2_instr", instr_a,         32'h0000_0043);
      for (int i = 0; i < 2; i++) begin
         step(); @(negedge clk);
         chk("wait_req",   32'(imem_a.imemReq), 32'd1);
         chk("wait_addr",  imem_a.imemAddr,     32'h8);
         chk("wait_vld",   32'(vld_a),          32'd0);
         chk("wait_instr", instr_a,             32'h0000_0013);
      end
      // c7: ready returns
      step(); imem_a.imemReady = 1'b1;
      @(negedge clk);
      chk("w8_addr", imem_a.imemAddr, 32'h8);
      // c8: word@8 in decode; stall while 12 is accepted
      step(); stall = 1'b1;
      @(negedge clk);
      chk("d8_vld",   32'(vld_a), 32'd1);
      chk("d8_pcD",   pc_a,       32'h8);
      chk("d8_instr", instr_a,    32'h0000_0083);
      chk("d8_op",    32'(op_a),  32'h03);
      chk("d8_pc4D",  pc4_a,      32'hC);
      chk("d8_addr",  imem_a.imemAddr, 32'hC);
      // c9: HOLD
      step(); @(negedge clk);
      chk("hold_req", 32'(imem_a.imemReq), 32'd0);
      chk("hold_pcD", pc_a,                32'h8);
      chk("hold_vld", 32'(vld_a),          32'd1);
      // c10: release
      step(); stall = 1'b0;
      @(negedge clk);
      chk("rel_req", 32'(imem_a.imemReq), 32'd0);
      // c11
      step(); @(negedge clk);
      chk("skid_pcD",   pc_a,            32'hC);
      chk("skid_instr", instr_a,         32'h0000_00C3);
      chk("skid_op",    32'(op_a),       32'h43);
      chk("skid_addr",  imem_a.imemAddr, 32'h10);
      // c12
      step(); @(negedge clk);
      chk("nodup_pcD", pc_a,            32'h10);
      chk("nodup_addr", imem_a.imemAddr, 32'h14);
      // c13, c14
      step(); step();
      // c15: addr 0x20 left outstanding
      step(); imem_a.imemReady = 1'b0;
      @(negedge clk);
      chk("a20_addr", imem_a.imemAddr, 32'h20);
      // c16: redirect to 0x100
      step(); redirect = 1'b1; pcSrc = 2'b01; pcTarget = 32'h0000_0100;
      @(negedge clk);
      // c17: DROP keeps stale address
      step(); redirect = 1'b0; pcSrc = 2'b00;
      @(negedge clk);
      chk("drop_req",  32'(imem_a.imemReq), 32'd1);
      chk("drop_addr", imem_a.imemAddr,     32'h20);
      chk("drop_vld",  32'(vld_a),          32'd0);
      // c18: stale response arrives
      step(); imem_a.imemReady = 1'b1;
      @(negedge clk);
      chk("stale_addr", imem_a.imemAddr, 32'h20);
      // c19
      step(); @(negedge clk);
      chk("tgt_addr",  imem_a.imemAddr, 32'h100);
      chk("stale_vld", 32'(vld_a),      32'd0);
      // c20: word@0x100, then trap redirect
      step(); redirect = 1'b1; pcSrc = 2'b10; trapVec = 32'h0000_0203;
      @(negedge clk);
      chk("tgt_vld",   32'(vld_a), 32'd1);
      chk("tgt_pcD",   pc_a,       32'h100);
      chk("tgt_instr", instr_a,    32'h0000_1003);
      // c21
      step(); redirect = 1'b0; pcSrc = 2'b00;
      @(negedge clk);
      chk("trap_addr", imem_a.imemAddr, 32'h200);
      chk("trap_vld",  32'(vld_a),      32'd0);
      // c22: flush alone
      step(); flush = 1'b1;
      @(negedge clk);
      chk("t200_pcD", pc_a, 32'h200);
      // c23
      step(); flush = 1'b0;
      @(negedge clk);
      chk("flush_vld",   32'(vld_a),      32'd0);
      chk("flush_instr", instr_a,         32'h0000_0013);
      chk("flush_addr",  imem_a.imemAddr, 32'h204);
      // c24: refetched 0x204, then leave 0x208 waiting
      step(); imem_a.imemReady = 1'b0;
      @(negedge clk);
      chk("refetch_pcD", pc_a, 32'h204);
      // c25: reset mid-wait
      step(); rst = 1'b1;
      @(negedge clk);
      chk("mid_req",  32'(imem_a.imemReq), 32'd1);
      chk("mid_addr", imem_a.imemAddr,     32'h208);
      // c26
      step(); rst = 1'b0;
      @(negedge clk);
      chk("mrst_req", 32'(imem_a.imemReq), 32'd0);
      chk("mrst_vld", 32'(vld_a),          32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
